lbus_axi_mport_bridge: RTL and testbench
========================================

LBUS_AXI_MPORT_BRIDGE -- requirements
Module: lbus_axi_mport_bridge

Interface
REQ-001 SHALL have parameter AddrW, default 32, bus/AXI address width.
REQ-002 SHALL have parameter DataW, default 64, data width; power of two, at least 8.
REQ-003 SHALL have parameter AxiIdW, default 6, AXI ID width; must be at least clog2(NumPort).
REQ-004 SHALL have parameter NumPort, default 2, number of local-bus requester ports; must be at least 1.
REQ-005 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, asynchronous, active-high); one clock, async active-high reset, as decided.
REQ-006 SHALL have per-port local-bus inputs, each a packed array over NumPort: bus_req (1), bus_id (AxiIdW), bus_strb (DataW/8), bus_addr (AddrW), bus_wdata (DataW).
REQ-007 SHALL have per-port local-bus outputs, packed over NumPort: bus_readyo (1), bus_ido (AxiIdW), bus_rdatao (DataW), bus_busyo (1), bus_erro (1).
REQ-008 SHALL have AXI write ports axi_awready, axi_wready, axi_bvalid and axi_bresp[1:0] as inputs.
REQ-009 SHALL have AXI write outputs axi_awido, axi_awaddro, axi_awleno[3:0], axi_awsizeo[2:0], axi_awbursto[1:0], axi_awvalido, axi_wdatao, axi_wstrbo, axi_wlasto, axi_wvalido and axi_breadyo.
REQ-010 SHALL have AXI read ports axi_arready, axi_rvalid, axi_rdata and axi_rresp[1:0] as inputs.
REQ-011 SHALL have AXI read outputs axi_arido, axi_araddro, axi_arleno, axi_arsizeo, axi_arbursto, axi_arvalido and axi_rreadyo.

Function
REQ-012 SHALL treat bus_req[p] as a one-cycle pulse; when bus_busyo[p]=0 it captures id/strb/addr/wdata into port p's holding register and sets pending[p]. A pulse while busy is ignored.
REQ-013 SHALL classify a request as a write when strb is nonzero and as a read when strb==0.
REQ-014 SHALL assert bus_busyo[p] from the cycle after capture through the cycle bus_readyo[p] pulses; it is deasserted the following cycle.
REQ-015 SHALL grant among pending ports round-robin: search starts at last_grant+1 modulo NumPort; last_grant updates only on completion.
REQ-016 SHALL run the FSM IDLE -> WR (AW+W issued together) -> BWAIT -> RESP for writes, and IDLE -> RD -> RWAIT -> RESP for reads.
REQ-017 In WR, SHALL hold awvalid and wvalid independently until each handshakes, in any cycle order; it goes to BWAIT once both are done.
REQ-018 SHALL drive single-beat transfers: len=0, size=clog2(DataW/8), burst=INCR (2'b01), wlast=1 with wvalid. Address is passed through unaligned-as-given.
REQ-019 SHALL drive AXI ID = granted port index, zero-extended to AxiIdW; the captured bus_id is returned on bus_ido.
REQ-020 SHALL assert bready only in BWAIT and rready only in RWAIT; bvalid/rvalid in other states are left unaccepted.
REQ-021 SHALL register rdata on the rvalid&rready handshake; writes return rdata=0.
REQ-022 In RESP, SHALL pulse bus_readyo[grant] for exactly one cycle with bus_rdatao/bus_ido valid, clear pending[grant], and return to IDLE. Minimum capture-to-ready latency is 4 cycles with zero-wait AXI.
REQ-023 When bus_req[p] arrives in the same cycle port p is being granted, SHALL ignore it, since busy is already high.
REQ-024 With all ports pending simultaneously, SHALL serve each exactly once before any port is served twice.

Reset
REQ-025 On reset SHALL drive all valid/ready/readyo/busyo/erro outputs to 0, clear pending, set last_grant=NumPort-1, put the FSM in IDLE, and zero the data/address outputs.
REQ-026 Reset mid-transaction SHALL abandon the transaction without completion; no readyo pulse follows.

Configuration
REQ-027 With LBUS_AXI_RESP_ERR_EN defined, SHALL pulse bus_erro[grant] with readyo when the captured bresp/rresp is nonzero.
REQ-028 Without LBUS_AXI_RESP_ERR_EN, SHALL tie bus_erro to 0 and ignore bresp/rresp.

Structure
REQ-029 Package lbus_axi_pkg SHALL hold the FSM state enum, AXI_BURST_INCR, and the AXI resp constants (OKAY, SLVERR, DECERR).
REQ-030 Round-robin selection SHALL be the sub-module rr_arbiter (NumPort, req vector, last_grant in, one-hot grant plus index out).

Verification
REQ-031 Write test: port0 writes addr 0x1000_0040, data 0x1122334455667788, strb 0xFF -> AWADDR 0x10000040, AWID 0, WSTRB 0xFF, WLAST=1; after B, readyo[0] pulses once.
REQ-032 Read test: port1 reads addr 0x80 with strb 0; slave returns 0xDEADBEEF_CAFEF00D -> bus_rdatao[1] carries that value and bus_ido[1] equals the sent id.
REQ-033 Arbitration test: both ports pulse req in the same cycle after reset -> port0 served first, then port1; with both re-requesting, the next order is 0, 1.
REQ-034 Handshake-skew test: awready asserted 3 cycles before wready -> exactly one AW and one W handshake, then BWAIT.
REQ-035 Busy-drop test: req pulse on a busy port is dropped -> exactly one AXI transaction and one readyo.
REQ-036 Error/reset test: bresp=2'b10 -> erro pulses with the macro and stays 0 without it; reset asserted in RWAIT -> rready=0 next cycle, no readyo.

Source files
------------

// File: rtl/lbus_axi_pkg.sv
// Shared types and AXI constants for the multi-port local-bus to AXI bridge.
package lbus_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_BWAIT,
    ST_RD,
    ST_RWAIT,
    ST_RESP
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches pending requests starting one past the last grant.
module rr_arbiter #(
  parameter int NumPort = 2,
  parameter int IdxW    = (NumPort > 1) ? $clog2(NumPort) : 1
) (
  input  logic [NumPort-1:0] i_req,
  input  logic [IdxW-1:0]    i_last_grant,
  output logic [NumPort-1:0] o_grant,
  output logic [IdxW-1:0]    o_grant_idx
);

  logic [IdxW-1:0] w_pos;
  logic            w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_pos       = '0;
    w_found     = 1'b0;
    // The last granted port is examined last, giving it lowest priority.
    for (int i = 1; i <= NumPort; i++) begin
      w_pos = IdxW'((int'(i_last_grant) + i) % NumPort);
      if (!w_found && i_req[w_pos]) begin
        w_found          = 1'b1;
        o_grant[w_pos]   = 1'b1;
        o_grant_idx      = w_pos;
      end
    end
  end

endmodule

// File: rtl/lbus_axi_mport_bridge.sv
// Multi-port local-bus requester to single-beat AXI master bridge.
// Optional LBUS_AXI_RESP_ERR_EN: report nonzero bresp/rresp on bus_erro.
module lbus_axi_mport_bridge
  import lbus_axi_pkg::*;
#(
  parameter int AddrW   = 32,
  parameter int DataW   = 64,
  parameter int AxiIdW  = 6,
  parameter int NumPort = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NumPort-1:0]                bus_req,
  input  logic [NumPort-1:0][AxiIdW-1:0]    bus_id,
  input  logic [NumPort-1:0][DataW/8-1:0]   bus_strb,
  input  logic [NumPort-1:0][AddrW-1:0]     bus_addr,
  input  logic [NumPort-1:0][DataW-1:0]     bus_wdata,
  output logic [NumPort-1:0]                bus_readyo,
  output logic [NumPort-1:0][AxiIdW-1:0]    bus_ido,
  output logic [NumPort-1:0][DataW-1:0]     bus_rdatao,
  output logic [NumPort-1:0]                bus_busyo,
  output logic [NumPort-1:0]                bus_erro,
  input  logic                              axi_awready,
  input  logic                              axi_wready,
  input  logic                              axi_bvalid,
  input  logic [1:0]                        axi_bresp,
  output logic [AxiIdW-1:0]                 axi_awido,
  output logic [AddrW-1:0]                  axi_awaddro,
  output logic [3:0]                        axi_awleno,
  output logic [2:0]                        axi_awsizeo,
  output logic [1:0]                        axi_awbursto,
  output logic                              axi_awvalido,
  output logic [DataW-1:0]                  axi_wdatao,
  output logic [DataW/8-1:0]                axi_wstrbo,
  output logic                              axi_wlasto,
  output logic                              axi_wvalido,
  output logic                              axi_breadyo,
  input  logic                              axi_arready,
  input  logic                              axi_rvalid,
  input  logic [DataW-1:0]                  axi_rdata,
  input  logic [1:0]                        axi_rresp,
  output logic [AxiIdW-1:0]                 axi_arido,
  output logic [AddrW-1:0]                  axi_araddro,
  output logic [3:0]                        axi_arleno,
  output logic [2:0]                        axi_arsizeo,
  output logic [1:0]                        axi_arbursto,
  output logic                              axi_arvalido,
  output logic                              axi_rreadyo
);

  localparam int         StrbW   = DataW / 8;
  localparam int         IdxW    = (NumPort > 1) ? $clog2(NumPort) : 1;
  localparam logic [2:0] AxiSize = 3'($clog2(StrbW));

  logic [AxiIdW-1:0] r_hid    [NumPort];
  logic [StrbW-1:0]  r_hstrb  [NumPort];
  logic [AddrW-1:0]  r_haddr  [NumPort];
  logic [DataW-1:0]  r_hwdata [NumPort];

  state_t            r_state;
  logic [NumPort-1:0] r_pending;
  logic [NumPort-1:0] r_gnt_oh;
  logic [IdxW-1:0]   r_gidx;
  logic [IdxW-1:0]   r_last;
  logic              r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [NumPort-1:0] r_readyo, r_erro;
  logic [AddrW-1:0]  r_axaddr;
  logic [AxiIdW-1:0] r_axid;
  logic [DataW-1:0]  r_wdata;
  logic [StrbW-1:0]  r_wstrb;
  logic [DataW-1:0]  r_rdata;
  logic [AxiIdW-1:0] r_ido;

  logic [NumPort-1:0] w_cap, w_clr, w_gnt_oh;
  logic [IdxW-1:0]    w_gnt_idx;
  logic               w_aw_done, w_w_done, w_b_err, w_r_err;

  // A request is only accepted by an idle port; pulses while busy are dropped.
  assign w_cap     = bus_req & ~r_pending;
  assign w_clr     = (r_state == ST_RESP) ? r_gnt_oh : '0;
  assign w_aw_done = ~r_awvalid | axi_awready;
  assign w_w_done  = ~r_wvalid | axi_wready;

`ifdef LBUS_AXI_RESP_ERR_EN
  assign w_b_err = resp_is_err(axi_bresp);
  assign w_r_err = resp_is_err(axi_rresp);
`else
  logic w_unused_resp;
  assign w_unused_resp = ^{axi_bresp, axi_rresp};
  assign w_b_err       = 1'b0;
  assign w_r_err       = 1'b0;
`endif

  rr_arbiter #(
    .NumPort (NumPort),
    .IdxW    (IdxW)
  ) u_arb (
    .i_req        (r_pending),
    .i_last_grant (r_last),
    .o_grant      (w_gnt_oh),
    .o_grant_idx  (w_gnt_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NumPort; p++) begin
        r_hid[p]    <= '0;
        r_hstrb[p]  <= '0;
        r_haddr[p]  <= '0;
        r_hwdata[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NumPort; p++) begin
        if (w_cap[p]) begin
          r_hid[p]    <= bus_id[p];
          r_hstrb[p]  <= bus_strb[p];
          r_haddr[p]  <= bus_addr[p];
          r_hwdata[p] <= bus_wdata[p];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_gnt_oh  <= '0;
      r_gidx    <= '0;
      r_last    <= IdxW'(NumPort - 1);
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_readyo  <= '0;
      r_erro    <= '0;
      r_axaddr  <= '0;
      r_axid    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_ido     <= '0;
    end else begin
      r_pending <= (r_pending | w_cap) & ~w_clr;
      case (r_state)
        ST_IDLE: begin
          if (|r_pending) begin
            r_gidx   <= w_gnt_idx;
            r_gnt_oh <= w_gnt_oh;
            r_axaddr <= r_haddr[w_gnt_idx];
            r_axid   <= AxiIdW'(w_gnt_idx);
            r_ido    <= r_hid[w_gnt_idx];
            r_wdata  <= r_hwdata[w_gnt_idx];
            r_wstrb  <= r_hstrb[w_gnt_idx];
            if (|r_hstrb[w_gnt_idx]) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD;
            end
          end
        end
        ST_WR: begin
          // AW and W complete independently, in either order.
          if (r_awvalid && axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && axi_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_BWAIT;
          end
        end
        ST_BWAIT: begin
          if (axi_bvalid) begin
            r_bready <= 1'b0;
            r_rdata  <= '0;
            r_readyo <= r_gnt_oh;
            r_erro   <= w_b_err ? r_gnt_oh : '0;
            r_state  <= ST_RESP;
          end
        end
        ST_RD: begin
          if (axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (axi_rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= axi_rdata;
            r_readyo <= r_gnt_oh;
            r_erro   <= w_r_err ? r_gnt_oh : '0;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_readyo <= '0;
          r_erro   <= '0;
          r_last   <= r_gidx;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read data and id are broadcast; each port qualifies them with its readyo.
  for (genvar p = 0; p < NumPort; p++) begin : g_port
    assign bus_rdatao[p] = r_rdata;
    assign bus_ido[p]    = r_ido;
  end

  assign bus_readyo   = r_readyo;
  assign bus_busyo    = r_pending;
  assign bus_erro     = r_erro;

  assign axi_awido    = r_axid;
  assign axi_awaddro  = r_axaddr;
  assign axi_awleno   = 4'd0;
  assign axi_awsizeo  = AxiSize;
  assign axi_awbursto = AXI_BURST_INCR;
  assign axi_awvalido = r_awvalid;
  assign axi_wdatao   = r_wdata;
  assign axi_wstrbo   = r_wstrb;
  assign axi_wlasto   = r_wvalid;
  assign axi_wvalido  = r_wvalid;
  assign axi_breadyo  = r_bready;

  assign axi_arido    = r_axid;
  assign axi_araddro  = r_axaddr;
  assign axi_arleno   = 4'd0;
  assign axi_arsizeo  = AxiSize;
  assign axi_arbursto = AXI_BURST_INCR;
  assign axi_arvalido = r_arvalid;
  assign axi_rreadyo  = r_rready;

endmodule

// File: tb/tb_lbus_axi_mport_bridge.sv
// Directed bench for lbus_axi_mport_bridge (default parameters, two ports).
module tb_lbus_axi_mport_bridge;

  logic             clk;
  logic             reset;
  logic [1:0]       bus_req;
  logic [1:0][5:0]  bus_id;
  logic [1:0][7:0]  bus_strb;
  logic [1:0][31:0] bus_addr;
  logic [1:0][63:0] bus_wdata;
  logic [1:0]       bus_readyo;
  logic [1:0][5:0]  bus_ido;
  logic [1:0][63:0] bus_rdatao;
  logic [1:0]       bus_busyo;
  logic [1:0]       bus_erro;
  logic             axi_awready, axi_wready, axi_bvalid;
  logic [1:0]       axi_bresp;
  logic [5:0]       axi_awido;
  logic [31:0]      axi_awaddro;
  logic [3:0]       axi_awleno;
  logic [2:0]       axi_awsizeo;
  logic [1:0]       axi_awbursto;
  logic             axi_awvalido;
  logic [63:0]      axi_wdatao;
  logic [7:0]       axi_wstrbo;
  logic             axi_wlasto, axi_wvalido, axi_breadyo;
  logic             axi_arready, axi_rvalid;
  logic [63:0]      axi_rdata;
  logic [1:0]       axi_rresp;
  logic [5:0]       axi_arido;
  logic [31:0]      axi_araddro;
  logic [3:0]       axi_arleno;
  logic [2:0]       axi_arsizeo;
  logic [1:0]       axi_arbursto;
  logic             axi_arvalido, axi_rreadyo;

  int n_chk  = 0;
  int n_pass = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0;
  int s_aw, s_w, s_ar, s_r0, s_r1;

  lbus_axi_mport_bridge dut (
    .clk(clk), .reset(reset),
    .bus_req(bus_req), .bus_id(bus_id), .bus_strb(bus_strb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_readyo(bus_readyo), .bus_ido(bus_ido), .bus_rdatao(bus_rdatao),
    .bus_busyo(bus_busyo), .bus_erro(bus_erro),
    .axi_awready(axi_awready), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp),
    .axi_awido(axi_awido), .axi_awaddro(axi_awaddro), .axi_awleno(axi_awleno),
    .axi_awsizeo(axi_awsizeo), .axi_awbursto(axi_awbursto),
    .axi_awvalido(axi_awvalido), .axi_wdatao(axi_wdatao), .axi_wstrbo(axi_wstrbo),
    .axi_wlasto(axi_wlasto), .axi_wvalido(axi_wvalido), .axi_breadyo(axi_breadyo),
    .axi_arready(axi_arready), .axi_rvalid(axi_rvalid),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_arido(axi_arido), .axi_araddro(axi_araddro), .axi_arleno(axi_arleno),
    .axi_arsizeo(axi_arsizeo), .axi_arbursto(axi_arbursto),
    .axi_arvalido(axi_arvalido), .axi_rreadyo(axi_rreadyo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (axi_awvalido && axi_awready) aw_cnt <= aw_cnt + 1;
    if (axi_wvalido && axi_wready)   w_cnt  <= w_cnt + 1;
    if (axi_arvalido && axi_arready) ar_cnt <= ar_cnt + 1;
    if (bus_readyo[0]) rdy0_cnt <= rdy0_cnt + 1;
    if (bus_readyo[1]) rdy1_cnt <= rdy1_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req_on(input int p, input logic [5:0] id, input logic [7:0] strb,
                        input logic [31:0] addr, input logic [63:0] data);
    bus_id[p]    = id;
    bus_strb[p]  = strb;
    bus_addr[p]  = addr;
    bus_wdata[p] = data;
    bus_req[p]   = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; bus_req = '0; bus_id = '0; bus_strb = '0; bus_addr = '0; bus_wdata = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00;
    cyc(2);
    chk("rst_awvalid", axi_awvalido, 0);
    chk("rst_wvalid",  axi_wvalido, 0);
    chk("rst_arvalid", axi_arvalido, 0);
    chk("rst_bready",  axi_breadyo, 0);
    chk("rst_rready",  axi_rreadyo, 0);
    chk("rst_readyo",  bus_readyo, 0);
    chk("rst_busyo",   bus_busyo, 0);
    chk("rst_erro",    bus_erro, 0);
    chk("rst_awaddr",  axi_awaddro, 0);
    chk("rst_rdatao",  bus_rdatao[0], 0);
    reset = 1'b0;
    cyc(1);

    // Write from port 0 with zero-wait slave
    axi_awready = 1'b1; axi_wready = 1'b1;
    s_r0 = rdy0_cnt;
    req_on(0, 6'h05, 8'hFF, 32'h1000_0040, 64'h1122334455667788);
    cyc(1); bus_req = '0;
    chk("wr_busy_after_cap", bus_busyo, 2'b01);
    chk("wr_idle_no_aw", axi_awvalido, 0);
    cyc(1);
    chk("wr_awvalid", axi_awvalido, 1);
    chk("wr_wvalid",  axi_wvalido, 1);
    chk("wr_awaddr",  axi_awaddro, 64'h1000_0040);
    chk("wr_awid",    axi_awido, 0);
    chk("wr_wstrb",   axi_wstrbo, 8'hFF);
    chk("wr_wlast",   axi_wlasto, 1);
    chk("wr_wdata",   axi_wdatao, 64'h1122334455667788);
    chk("wr_awlen",   axi_awleno, 0);
    chk("wr_awsize",  axi_awsizeo, 3);
    chk("wr_awburst", axi_awbursto, 2'b01);
    cyc(1);
    chk("wr_aw_done", axi_awvalido, 0);
    chk("wr_bready",  axi_breadyo, 1);
    axi_bvalid = 1'b1; axi_bresp = 2'b00;
    cyc(1); axi_bvalid = 1'b0;
    chk("wr_readyo",  bus_readyo, 2'b01);
    chk("wr_ido",     bus_ido[0], 6'h05);
    chk("wr_rdata0",  bus_rdatao[0], 0);
    chk("wr_busy_resp", bus_busyo, 2'b01);
    chk("wr_erro_ok", bus_erro, 0);
    cyc(1);
    chk("wr_readyo_end", bus_readyo, 0);
    chk("wr_busy_end",   bus_busyo, 0);
    chk("wr_rdy_pulses", rdy0_cnt - s_r0, 1);

    // Read from port 1
    axi_arready = 1'b1;
    req_on(1, 6'h2A, 8'h00, 32'h0000_0080, 64'h0);
    cyc(1); bus_req = '0;
    cyc(1);
    chk("rd_arvalid", axi_arvalido, 1);
    chk("rd_araddr",  axi_araddro, 32'h80);
    chk("rd_arid",    axi_arido, 1);
    chk("rd_arlen",   axi_arleno, 0);
    chk("rd_arsize",  axi_arsizeo, 3);
    chk("rd_arburst", axi_arbursto, 2'b01);
    chk("rd_no_aw",   axi_awvalido, 0);
    cyc(1);
    chk("rd_rready",  axi_rreadyo, 1);
    chk("rd_ar_done", axi_arvalido, 0);
    axi_rvalid = 1'b1; axi_rdata = 64'hDEADBEEF_CAFEF00D;
    cyc(1); axi_rvalid = 1'b0;
    chk("rd_readyo",  bus_readyo, 2'b10);
    chk("rd_rdata",   bus_rdatao[1], 64'hDEADBEEF_CAFEF00D);
    chk("rd_ido",     bus_ido[1], 6'h2A);
    cyc(1);
    chk("rd_busy_end", bus_busyo, 0);

    // Arbitration: two rounds of simultaneous requests after reset
    do_reset();
    axi_rvalid = 1'b1; axi_rdata = 64'h55;
    for (int r = 0; r < 2; r++) begin
      req_on(0, 6'(2*r + 1), 8'h00, 32'h100, 64'h0);
      req_on(1, 6'(2*r + 2), 8'h00, 32'h200, 64'h0);
      cyc(1); bus_req = '0;
      cyc(1);
      chk("arb_first_id",   axi_arido, 0);
      chk("arb_first_addr", axi_araddro, 32'h100);
      cyc(2);
      chk("arb_first_rdy",  bus_readyo, 2'b01);
      chk("arb_first_ido",  bus_ido[0], 6'(2*r + 1));
      cyc(2);
      chk("arb_second_id",   axi_arido, 1);
      chk("arb_second_addr", axi_araddro, 32'h200);
      cyc(2);
      chk("arb_second_rdy",  bus_readyo, 2'b10);
      chk("arb_second_ido",  bus_ido[1], 6'(2*r + 2));
      cyc(1);
      chk("arb_idle_busy",   bus_busyo, 0);
    end
    axi_rvalid = 1'b0;

    // Handshake skew: awready three cycles ahead of wready, then SLVERR
    axi_awready = 1'b0; axi_wready = 1'b0;
    s_aw = aw_cnt; s_w = w_cnt;
    req_on(0, 6'h07, 8'h0F, 32'h2000, 64'hA5A5_5A5A_0F0F_F0F0);
    cyc(1); bus_req = '0;
    cyc(1);
    chk("sk_awvalid", axi_awvalido, 1);
    chk("sk_wstrb",   axi_wstrbo, 8'h0F);
    axi_awready = 1'b1;
    cyc(1);
    chk("sk_aw_done",  axi_awvalido, 0);
    chk("sk_w_hold1",  axi_wvalido, 1);
    chk("sk_no_bready1", axi_breadyo, 0);
    cyc(1);
    chk("sk_w_hold2",  axi_wvalido, 1);
    chk("sk_no_bready2", axi_breadyo, 0);
    cyc(1);
    axi_wready = 1'b1;
    cyc(1);
    chk("sk_w_done",  axi_wvalido, 0);
    chk("sk_bready",  axi_breadyo, 1);
    chk("sk_aw_count", aw_cnt - s_aw, 1);
    chk("sk_w_count",  w_cnt - s_w, 1);
    axi_bvalid = 1'b1; axi_bresp = 2'b10;
    cyc(1); axi_bvalid = 1'b0; axi_bresp = 2'b00;
    chk("err_readyo", bus_readyo, 2'b01);
`ifdef LBUS_AXI_RESP_ERR_EN
    chk("err_erro", bus_erro, 2'b01);
`else
    chk("err_erro", bus_erro, 2'b00);
`endif
    cyc(1);
    chk("err_erro_end", bus_erro, 0);

    // Busy drop: extra pulses on port 1 while it is pending
    axi_arready = 1'b1; axi_rvalid = 1'b0;
    s_ar = ar_cnt; s_r1 = rdy1_cnt;
    req_on(1, 6'h09, 8'h00, 32'h300, 64'h0);
    cyc(1);
    chk("bd_busy", bus_busyo, 2'b10);
    bus_id[1] = 6'h11; bus_addr[1] = 32'h399;
    cyc(1); bus_req = '0;
    chk("bd_araddr", axi_araddro, 32'h300);
    cyc(1);
    chk("bd_rready", axi_rreadyo, 1);
    req_on(1, 6'h12, 8'h00, 32'h3AA, 64'h0);
    cyc(1); bus_req = '0;
    cyc(1);
    axi_rvalid = 1'b1; axi_rdata = 64'h0123456789ABCDEF;
    cyc(1); axi_rvalid = 1'b0;
    chk("bd_readyo", bus_readyo, 2'b10);
    chk("bd_ido",    bus_ido[1], 6'h09);
    chk("bd_rdata",  bus_rdatao[1], 64'h0123456789ABCDEF);
    cyc(6);
    chk("bd_ar_count",  ar_cnt - s_ar, 1);
    chk("bd_rdy_count", rdy1_cnt - s_r1, 1);
    chk("bd_busy_end",  bus_busyo, 0);
    chk("bd_no_ar",     axi_arvalido, 0);

    // Reset while waiting for read data
    s_r0 = rdy0_cnt;
    req_on(0, 6'h03, 8'h00, 32'h400, 64'h0);
    cyc(1); bus_req = '0;
    cyc(2);
    chk("rr_rready", axi_rreadyo, 1);
    reset = 1'b1; axi_rvalid = 1'b1;
    cyc(1);
    chk("rr_rready_rst", axi_rreadyo, 0);
    chk("rr_busy_rst",   bus_busyo, 0);
    chk("rr_readyo_rst", bus_readyo, 0);
    reset = 1'b0;
    cyc(5);
    chk("rr_no_readyo", rdy0_cnt - s_r0, 0);
    chk("rr_rready_end", axi_rreadyo, 0);
    chk("rr_busy_end",   bus_busyo, 0);
    axi_rvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
